// File: rtl/serial_bit_loader.sv
// Serial-to-parallel load sequencer driving a bank of negedge load-enabled bit cells.
// Optional MSB-first ordering is selected with `define SERIAL_LOADER_MSB_FIRST_EN.
module serial_bit_loader #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             ser_in,
    output logic [WIDTH-1:0] load_bus,
    output logic             d_out,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
`ifdef SERIAL_LOADER_MSB_FIRST_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(WIDTH - 32'sd1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_ZERO;
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_ZERO;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 32'sd1);
`endif

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] idx_step_s;
    logic [WIDTH-1:0] load_bus_s;

    // Step toward the last index; the DONE transition stops it before any unused code.
`ifdef SERIAL_LOADER_MSB_FIRST_EN
    assign idx_step_s = idx_r - IDX_ONE;
`else
    assign idx_step_s = idx_r + IDX_ONE;
`endif

    // State and index registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state and next-index selection; abort beats start and completion.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                idx_s = FIRST_IDX;
                if (start && !abort) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_s = IDLE;
                    idx_s   = FIRST_IDX;
                end else if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                    idx_s   = idx_r;
                end else begin
                    state_s = SHIFT;
                    idx_s   = idx_step_s;
                end
            end
            DONE: begin
                state_s = IDLE;
                idx_s   = FIRST_IDX;
            end
            default: begin
                state_s = IDLE;
                idx_s   = FIRST_IDX;
            end
        endcase
    end

    // One-hot decode of the index; compared per bit so no out-of-range code can select a cell.
    always_comb begin
        load_bus_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            load_bus_s[i] = (state_r == SHIFT) && (idx_r == IDX_W'(i));
        end
    end

    // Outputs are decoded straight from the registered state so reset clears them at once.
    assign load_bus = load_bus_s;
    assign d_out    = (state_r == SHIFT) ? ser_in : 1'b0;
    assign busy     = (state_r == SHIFT);
    assign done     = (state_r == DONE);
    assign idx      = idx_r;

endmodule
